// File: rtl/clock_frequency_divider_pkg.sv
// Board-level clocking constants shared by the divider and the blocks that instantiate it.
package clock_frequency_divider_pkg;

    localparam int CLK_SYS_HZ = 50_000_000;

endpackage

// File: rtl/clock_frequency_divider.sv
// Divides InClock to a 50%-duty registered square wave, with a one-cycle strobe on each rise.
// OutClock is driven straight from a flop so it can safely feed downstream clock pins.
module clock_frequency_divider
    import clock_frequency_divider_pkg::*;
#(
    parameter int INPUT_FREQUENCY  = CLK_SYS_HZ,
    parameter int OUTPUT_FREQUENCY = 1
) (
    input  logic InClock,
    input  logic reset,
    output logic OutClock,
    output logic OutTick
);

    // Guard the division so a zero output frequency reaches the $error below instead of a divide fault.
    localparam int HALF_PERIOD = (OUTPUT_FREQUENCY == 0) ? 0
                               : INPUT_FREQUENCY / (2 * OUTPUT_FREQUENCY);
    localparam int HALF_PERIOD_SAFE = (HALF_PERIOD < 1) ? 1 : HALF_PERIOD;
    localparam int CNT_W = (HALF_PERIOD_SAFE <= 1) ? 1 : $clog2(HALF_PERIOD_SAFE);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(HALF_PERIOD_SAFE - 1);

    if (OUTPUT_FREQUENCY == 0) begin : g_err_zero_out
        $error("clock_frequency_divider: OUTPUT_FREQUENCY must be non-zero");
    end else if (HALF_PERIOD == 0) begin : g_err_ratio
        $error("clock_frequency_divider: OUTPUT_FREQUENCY %0d exceeds INPUT_FREQUENCY/2 (%0d)",
               OUTPUT_FREQUENCY, INPUT_FREQUENCY / 2);
    end

    logic [CNT_W-1:0] r_count;
    logic             r_out;
    logic             r_tick;

    always_ff @(posedge InClock) begin
        if (reset) begin
            r_count <= '0;
            r_out   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= '0;
            r_out   <= ~r_out;
            r_tick  <= ~r_out;
        end else begin
            r_count <= r_count + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    assign OutClock = r_out;
    assign OutTick  = r_tick;

endmodule

// File: tb/tb_clock_frequency_divider.sv
// Randomized-reset bench for the divider at three ratios, checked every cycle against an
// edge-count model plus a few hand-computed timing points.
module tb_clock_frequency_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic oc5, ot5, oc50, ot50, oc30, ot30;

    clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) u_div5 (
        .InClock(clk), .reset(rst), .OutClock(oc5), .OutTick(ot5));
    clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(50)) u_div50 (
        .InClock(clk), .reset(rst), .OutClock(oc50), .OutTick(ot50));
    clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(30)) u_div30 (
        .InClock(clk), .reset(rst), .OutClock(oc30), .OutTick(ot30));

    int compared   = 0;
    int mismatched = 0;

    // Model state: number of non-reset edges since the last reset edge.
    int   k       = 0;
    logic started = 1'b0;

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
        started <= 1'b1;
    end

    function automatic logic exp_clk(input int kk, input int h);
        return ((kk / h) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input int kk, input int h);
        return (kk > 0) && ((kk % (2 * h)) == h);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b, expected %b (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("hp5_clk",  oc5,  exp_clk(k, 5));
            check("hp5_tick", ot5,  exp_tick(k, 5));
            check("of50_clk", oc50, exp_clk(k, 1));
            check("of50_tick", ot50, exp_tick(k, 1));
            check("of30_clk", oc30, exp_clk(k, 1));
            check("of30_tick", ot30, exp_tick(k, 1));
        end
    end

    int highs;
    int ticks;
    bit found;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_clk_lit",  oc5, 1'b0);
        check("rst_tick_lit", ot5, 1'b0);
        rst = 1'b0;

        repeat (4) @(negedge clk);
        check("pre_rise_lit", oc5, 1'b0);
        @(negedge clk);
        check("rise5_clk_lit",  oc5, 1'b1);
        check("rise5_tick_lit", ot5, 1'b1);
        check("of50_k5_lit",    oc50, 1'b1);

        highs = 0;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (oc5 === 1'b1) highs++;
            if (ot5 === 1'b1) ticks++;
        end
        compared++;
        if (highs != 50) begin
            mismatched++;
            $display("FAIL freerun_high_cycles: got %0d, expected 50", highs);
        end
        compared++;
        if (ticks != 10) begin
            mismatched++;
            $display("FAIL freerun_tick_count: got %0d, expected 10", ticks);
        end

        // Mid-high-phase reset: OutClock high with internal count 2.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (k % 10 == 7) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL midreset_wait: phase k%%10==7 not reached, k=%0d", k);
        end
        check("midreset_pre_lit", oc5, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_clk_lit",  oc5, 1'b0);
        check("midreset_tick_lit", ot5, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_pre_rise_lit", oc5, 1'b0);
        @(negedge clk);
        check("midreset_rise_lit", oc5, 1'b1);

        // Random reset pulses, mostly single edges, occasionally a few edges long.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 2) != 0) rst = 1'b0;
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
